// File: rtl/icache_ctrl_pkg.sv
// rtl/icache_ctrl_pkg.sv - controller state encoding and datapath miss-handling codes
package icache_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MISS   = 2'd1,
      FILL   = 2'd2,
      SETTLE = 2'd3
   } icache_state_t;

   localparam logic [2:0] WCS_NONE  = 3'b000;
   localparam logic [2:0] WCS_FETCH = 3'b011;
   localparam logic [2:0] WCS_FILL  = 3'b111;

endpackage

// File: rtl/icache_control.sv
// rtl/icache_control.sv - 2-way instruction cache sequencer with saturating hit/miss counters
module icache_control
   import icache_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_read,
   output logic             mem_resp,
   output logic             pmem_read,
   input  logic             pmem_resp,
   input  logic             HIT,
   input  logic             way_hit,
   input  logic             lru_data,
   output logic             LD_LRU_in,
   output logic             lru_in_value,
   output logic [1:0]       LD_TAG,
   output logic [1:0]       LD_VALID,
   output logic             valid_in,
   output logic [2:0]       W_CACHE_STATUS,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   icache_state_t    state_q, state_d;
   logic             replay_q, replay_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;

   always_comb begin
      state_d        = state_q;
      replay_d       = replay_q;
      hit_count_d    = hit_count_q;
      miss_count_d   = miss_count_q;
      mem_resp       = 1'b0;
      pmem_read      = 1'b0;
      LD_LRU_in      = 1'b0;
      lru_in_value   = 1'b0;
      LD_TAG         = 2'b00;
      LD_VALID       = 2'b00;
      valid_in       = 1'b0;
      W_CACHE_STATUS = WCS_NONE;

      case (state_q)
         IDLE: begin
            replay_d = 1'b0;
            if (mem_read) begin
               if (HIT) begin
                  mem_resp     = 1'b1;
                  LD_LRU_in    = 1'b1;
                  lru_in_value = ~way_hit;
                  // the hit that replays a just-filled line was already counted as a miss
                  if (!replay_q && (hit_count_q != '1))
                     hit_count_d = hit_count_q + CNT_W'(1);
               end else begin
                  state_d = MISS;
                  if (miss_count_q != '1)
                     miss_count_d = miss_count_q + CNT_W'(1);
               end
            end
         end
         MISS: begin
            pmem_read      = 1'b1;
            W_CACHE_STATUS = WCS_FETCH;
            if (pmem_resp)
               state_d = FILL;
         end
         FILL: begin
            W_CACHE_STATUS   = WCS_FILL;
            LD_TAG[lru_data]   = 1'b1;
            LD_VALID[lru_data] = 1'b1;
            valid_in         = 1'b1;
            state_d          = SETTLE;
         end
         SETTLE: begin
            replay_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         replay_q     <= 1'b0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         state_q      <= state_d;
         replay_q     <= replay_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_control.sv
// tb/tb_icache_control.sv - randomized fetch stream against a transaction-level cache model
module tb_icache_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic [31:0] mem_address;
   logic        pmem_resp;
   logic        HIT, way_hit, lru_data;
   logic        env_clear;

   logic        mem_resp, pmem_read, LD_LRU_in, lru_in_value, valid_in;
   logic [1:0]  LD_TAG, LD_VALID;
   logic [2:0]  W_CACHE_STATUS;
   logic [31:0] hit_count, miss_count;

   logic        s_mem_resp, s_pmem_read, s_LD_LRU_in, s_lru_in_value, s_valid_in;
   logic [1:0]  s_LD_TAG, s_LD_VALID;
   logic [2:0]  s_W_CACHE_STATUS;
   logic [1:0]  s_hit_count, s_miss_count;

   int n_tests, n_fail;

   always #5 clk = ~clk;

   icache_control #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_resp(pmem_resp), .HIT(HIT), .way_hit(way_hit),
      .lru_data(lru_data), .LD_LRU_in(LD_LRU_in), .lru_in_value(lru_in_value),
      .LD_TAG(LD_TAG), .LD_VALID(LD_VALID), .valid_in(valid_in),
      .W_CACHE_STATUS(W_CACHE_STATUS), .hit_count(hit_count), .miss_count(miss_count)
   );

   icache_control #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(s_mem_resp),
      .pmem_read(s_pmem_read), .pmem_resp(pmem_resp), .HIT(HIT), .way_hit(way_hit),
      .lru_data(lru_data), .LD_LRU_in(s_LD_LRU_in), .lru_in_value(s_lru_in_value),
      .LD_TAG(s_LD_TAG), .LD_VALID(s_LD_VALID), .valid_in(s_valid_in),
      .W_CACHE_STATUS(s_W_CACHE_STATUS), .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   // Datapath stand-in: tag/valid/LRU arrays reacting to the main DUT's strobes
   logic [23:0] env_tag   [8][2];
   logic        env_valid [8][2];
   logic        env_lru   [8];
   wire  [2:0]  cur_idx = mem_address[7:5];
   wire  [23:0] cur_tag = mem_address[31:8];

   always_comb begin
      HIT     = 1'b0;
      way_hit = 1'b0;
      for (int w = 0; w < 2; w++)
         if (env_valid[cur_idx][w] === 1'b1 && env_tag[cur_idx][w] == cur_tag) begin
            HIT     = 1'b1;
            way_hit = w[0];
         end
      lru_data = env_lru[cur_idx];
   end

   always @(posedge clk) begin
      if (env_clear) begin
         for (int s = 0; s < 8; s++) begin
            env_lru[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               env_valid[s][w] <= 1'b0;
               env_tag[s][w]   <= '0;
            end
         end
      end else begin
         if (LD_LRU_in) env_lru[cur_idx] <= lru_in_value;
         for (int w = 0; w < 2; w++) begin
            if (LD_TAG[w])   env_tag[cur_idx][w]   <= cur_tag;
            if (LD_VALID[w]) env_valid[cur_idx][w] <= valid_in;
         end
      end
   end

   // Reference model: cache contents and counts tracked per transaction
   logic [23:0] ref_tag   [8][2];
   bit          ref_valid [8][2];
   bit          ref_lru   [8];
   int          ref_hits, ref_misses;

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_counters();
      chk("hit_count",    hit_count,    ref_hits);
      chk("miss_count",   miss_count,   ref_misses);
      chk("s_hit_count",  {30'd0, s_hit_count},  sat3(ref_hits));
      chk("s_miss_count", {30'd0, s_miss_count}, sat3(ref_misses));
   endtask

   task automatic fetch(input logic [31:0] addr, input int lat, input bit drop);
      int          idx;
      logic [23:0] tg;
      bit          hit;
      bit          w;
      bit          victim;
      idx = int'(addr[7:5]);
      tg  = addr[31:8];
      hit = 1'b0;
      w   = 1'b0;
      for (int i = 0; i < 2; i++)
         if (ref_valid[idx][i] && ref_tag[idx][i] == tg) begin
            hit = 1'b1;
            w   = i[0];
         end
      mem_address = addr;
      mem_read    = 1'b1;
      pmem_resp   = 1'b0;
      @(negedge clk);
      if (hit) begin
         chk("hit_resp",     mem_resp,     1);
         chk("hit_ld_lru",   LD_LRU_in,    1);
         chk("hit_lru_val",  lru_in_value, !w);
         chk("hit_no_pmem",  pmem_read,    0);
         chk("hit_no_ldtag", LD_TAG,       0);
         ref_lru[idx] = !w;
         ref_hits++;
         @(posedge clk); #1;
         mem_read = 1'b0;
      end else begin
         chk("miss_no_resp", mem_resp,  0);
         chk("miss_idle_pm", pmem_read, 0);
         ref_misses++;
         victim = ref_lru[idx];
         @(posedge clk); #1;
         if (drop) mem_read = 1'b0;
         for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("miss_pmem", pmem_read, 1);
            chk("miss_wcs",  W_CACHE_STATUS, 3'b011);
            @(posedge clk); #1;
         end
         pmem_resp = 1'b1;
         @(negedge clk);
         chk("resp_pmem", pmem_read, 1);
         chk("resp_wcs",  W_CACHE_STATUS, 3'b011);
         @(posedge clk); #1;
         pmem_resp = 1'b0;
         @(negedge clk);
         chk("fill_wcs",    W_CACHE_STATUS, 3'b111);
         chk("fill_ldtag",  LD_TAG,   victim ? 2'b10 : 2'b01);
         chk("fill_ldval",  LD_VALID, victim ? 2'b10 : 2'b01);
         chk("fill_valid",  valid_in, 1);
         chk("fill_pmem",   pmem_read, 0);
         chk("fill_resp",   mem_resp,  0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("settle_wcs",   W_CACHE_STATUS, 3'b000);
         chk("settle_ldtag", LD_TAG, 0);
         chk("settle_resp",  mem_resp, 0);
         chk("settle_pmem",  pmem_read, 0);
         ref_tag[idx][victim]   = tg;
         ref_valid[idx][victim] = 1'b1;
         @(posedge clk); #1;
         @(negedge clk);
         if (drop) begin
            chk("drop_no_resp", mem_resp, 0);
            chk("drop_no_lru",  LD_LRU_in, 0);
         end else begin
            chk("replay_resp",    mem_resp, 1);
            chk("replay_lru_val", lru_in_value, !victim);
            ref_lru[idx] = !victim;
         end
         @(posedge clk); #1;
         mem_read = 1'b0;
      end
      @(negedge clk);
      chk_counters();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a;
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b0;
      mem_read    = 1'b1;
      mem_address = 32'h0000_0060;
      pmem_resp   = 1'b0;
      env_clear   = 1'b1;
      ref_hits    = 0;
      ref_misses  = 0;
      for (int s = 0; s < 8; s++) begin
         ref_lru[s] = 1'b0;
         for (int w = 0; w < 2; w++) begin
            ref_valid[s][w] = 1'b0;
            ref_tag[s][w]   = '0;
         end
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_resp",  mem_resp, 0);
      chk("rst_pmem",  pmem_read, 0);
      chk("rst_ldlru", LD_LRU_in, 0);
      chk("rst_ldtag", LD_TAG, 0);
      chk("rst_ldval", LD_VALID, 0);
      chk("rst_wcs",   W_CACHE_STATUS, 0);
      chk_counters();
      @(posedge clk); #1;
      rst       = 1'b1;
      mem_read  = 1'b0;
      env_clear = 1'b0;
      @(negedge clk);
      chk("post_rst_pmem", pmem_read, 0);
      @(posedge clk); #1;

      fetch(32'h0000_0060, 5, 1'b0);
      fetch(32'h0000_0064, 0, 1'b0);
      fetch(32'h0001_0160, 3, 1'b0);
      fetch(32'h0001_0164, 0, 1'b0);
      fetch(32'h0000_0068, 0, 1'b0);
      fetch(32'h0001_0168, 0, 1'b0);
      fetch(32'h0000_006C, 0, 1'b0);

      fetch(32'h0000_00A0, 2, 1'b1);
      fetch(32'h0000_00A4, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         a = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 2'b00};
         fetch(a, $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
      end

      // Reset lands mid-miss; the late line response must be ignored
      mem_address = 32'h0000_5FC0;
      mem_read    = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst      = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      chk("midrst_pmem_hi", pmem_read, 1);
      @(posedge clk); #1;
      rst       = 1'b1;
      pmem_resp = 1'b1;
      ref_hits   = 0;
      ref_misses = 0;
      @(negedge clk);
      chk("midrst_pmem",  pmem_read, 0);
      chk("midrst_ldtag", LD_TAG, 0);
      chk("midrst_wcs",   W_CACHE_STATUS, 0);
      chk_counters();
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      @(negedge clk);
      chk("late_resp_ldtag", LD_TAG, 0);
      chk("late_resp_ldval", LD_VALID, 0);
      chk("late_resp_wcs",   W_CACHE_STATUS, 0);
      @(posedge clk); #1;

      for (int t = 0; t < 4; t++)
         fetch({22'd0, 2'(t), 3'd6, 5'd0} | 32'h0010_0000, 1, 1'b0);
      @(negedge clk);
      chk("sat_small_miss", {30'd0, s_miss_count}, 3);
      chk("sat_main_miss",  miss_count, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
